instr_fetch_unit: RTL and testbench

Fetch stage between the warp scheduler and the decoder. It accepts one PC plus warp number per request from the scheduler, issues a request/acknowledge read to instruction memory, and holds the returned instruction word with a valid/ready handshake until the decoder takes it. Only one fetch is in flight at a time. A watchdog aborts fetches that memory never acknowledges. A flush input discards in-flight work.

---
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/instr_fetch_unit.sv | 66 ++++++
 tb/tb_instr_fetch_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: scheduler, instruction-memory and decoder signals of the fetch stage
interface instr_fetch_unit_if #(
  parameter int PC_WIDTH = 8,
  parameter int INSTR_WIDTH = 18
);
  logic fetch_req;
  logic [PC_WIDTH-1:0] pc;
  logic [1:0] warp_num;
  logic fetch_ready;
  logic mem_req;
  logic [PC_WIDTH-1:0] mem_addr;
  logic mem_ack;
  logic [INSTR_WIDTH-1:0] mem_rdata;
  logic instr_valid;
  logic [INSTR_WIDTH-1:0] instr;
  logic [1:0] instr_warp;
  logic instr_ready;
  logic flush;
  logic fetch_error;
  logic [1:0] error_warp;
  modport master (
    input fetch_req, pc, warp_num, mem_ack, mem_rdata, instr_ready, flush,
    output fetch_ready, mem_req, mem_addr, instr_valid, instr, instr_warp, fetch_error, error_warp
  );
  modport slave (
    output fetch_req, pc, warp_num, mem_ack, mem_rdata, instr_ready, flush,
    input fetch_ready, mem_req, mem_addr, instr_valid, instr, instr_warp, fetch_error, error_warp
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetch with ack watchdog and flush
module instr_fetch_unit #(
  parameter int PC_WIDTH = 8,
  parameter int INSTR_WIDTH = 18,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic reset,
  instr_fetch_unit_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, VALID = 2'd2;
  logic [1:0] state, state_d;
  logic [CW-1:0] wait_cnt;
  logic [PC_WIDTH-1:0] addr_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [1:0] warp_q, err_warp_q;
  logic req_q, valid_q, err_q;
  logic ready, accept, ack, tmo, in_req;
  always_comb begin
    in_req = state == REQ;
    ready = state == IDLE || (state == VALID && bus.instr_ready);
    accept = ready && bus.fetch_req && !bus.flush;
    ack = in_req && bus.mem_ack && !bus.flush;
    tmo = in_req && !bus.mem_ack && !bus.flush && wait_cnt == CW'(TIMEOUT);
    state_d = bus.flush ? IDLE : ack ? VALID : tmo ? IDLE : accept ? REQ :
              (state == VALID && bus.instr_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wait_cnt <= '0;
      addr_q <= '0;
      instr_q <= '0;
      warp_q <= '0;
      err_warp_q <= '0;
      req_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      req_q <= state_d == REQ;
      valid_q <= state_d == VALID;
      if (accept) begin
        addr_q <= bus.pc;
        warp_q <= bus.warp_num;
        wait_cnt <= '0;
      end else if (in_req && !ack && !tmo) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (ack) instr_q <= bus.mem_rdata;
      if (tmo) begin
        err_q <= 1'b1;
        err_warp_q <= warp_q;
      end
    end
  end
  assign bus.fetch_ready = ready;
  assign bus.mem_req = req_q;
  assign bus.mem_addr = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr = instr_q;
  assign bus.instr_warp = warp_q;
  assign bus.fetch_error = err_q;
  assign bus.error_warp = err_warp_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed fetch scenarios with a queue scoreboard on the decoder handshake
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  logic [19:0] sb[$];
  always #5 clk = ~clk;
  instr_fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(18)) b();
  instr_fetch_unit dut (.clk(clk), .reset(reset), .bus(b));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_mem_req"}, 32'(b.mem_req), 0);
    chk({tag, "_mem_addr"}, 32'(b.mem_addr), 0);
    chk({tag, "_instr_valid"}, 32'(b.instr_valid), 0);
    chk({tag, "_instr"}, 32'(b.instr), 0);
    chk({tag, "_instr_warp"}, 32'(b.instr_warp), 0);
    chk({tag, "_fetch_error"}, 32'(b.fetch_error), 0);
    chk({tag, "_error_warp"}, 32'(b.error_warp), 0);
    chk({tag, "_fetch_ready"}, 32'(b.fetch_ready), 1);
  endtask
  task automatic start(input logic [7:0] p, input logic [1:0] w);
    b.fetch_req = 1'b1;
    b.pc = p;
    b.warp_num = w;
    tick();
    b.fetch_req = 1'b0;
  endtask
  task automatic run_timeout(input logic [1:0] w);
    int n = 0;
    start(8'h30, w);
    while (b.mem_req && n < 40) begin
      n++;
      tick();
    end
    chk("timeout_req_cycles", 32'(n), 16);
    chk("timeout_error", 32'(b.fetch_error), 1);
    chk("timeout_error_warp", 32'(b.error_warp), 32'(w));
    chk("timeout_ready", 32'(b.fetch_ready), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    b.fetch_req = 1'b0;
    b.pc = '0;
    b.warp_num = '0;
    b.mem_ack = 1'b0;
    b.mem_rdata = '0;
    b.instr_ready = 1'b1;
    b.flush = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (!reset && b.instr_valid && b.instr_ready) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got %0h expected no delivery", {b.instr_warp, b.instr});
          end else begin
            logic [19:0] e;
            e = sb.pop_front();
            if ({b.instr_warp, b.instr} !== e) begin
              failures++;
              $display("FAIL sb_instr: got %0h expected %0h", {b.instr_warp, b.instr}, e);
            end
          end
        end
      end
    join_none
    tick();
    tick();
    chk_reset("rst");
    reset = 1'b0;
    // basic fetch, ack in second REQ cycle
    sb.push_back({2'd2, 18'h2A5F3});
    start(8'h12, 2'd2);
    chk("basic_mem_req", 32'(b.mem_req), 1);
    chk("basic_mem_addr", 32'(b.mem_addr), 32'h12);
    chk("basic_busy", 32'(b.fetch_ready), 0);
    tick();
    b.mem_ack = 1'b1;
    b.mem_rdata = 18'h2A5F3;
    chk("basic_req_hold", 32'(b.mem_req), 1);
    tick();
    b.mem_ack = 1'b0;
    chk("basic_valid", 32'(b.instr_valid), 1);
    chk("basic_req_drop", 32'(b.mem_req), 0);
    tick();
    chk("basic_idle_valid", 32'(b.instr_valid), 0);
    chk("basic_idle_ready", 32'(b.fetch_ready), 1);
    // backpressure then back-to-back
    b.instr_ready = 1'b0;
    sb.push_back({2'd1, 18'h13456});
    start(8'h20, 2'd1);
    b.mem_ack = 1'b1;
    b.mem_rdata = 18'h13456;
    tick();
    b.mem_ack = 1'b0;
    b.mem_rdata = '0;
    for (int i = 0; i < 5; i++) begin
      b.fetch_req = i[0];
      b.pc = 8'h40;
      chk("bp_valid", 32'(b.instr_valid), 1);
      chk("bp_instr", 32'(b.instr), 32'h13456);
      chk("bp_warp", 32'(b.instr_warp), 1);
      chk("bp_ready", 32'(b.fetch_ready), 0);
      chk("bp_no_req", 32'(b.mem_req), 0);
      tick();
    end
    b.instr_ready = 1'b1;
    b.fetch_req = 1'b1;
    b.pc = 8'h13;
    b.warp_num = 2'd3;
    #1;
    chk("b2b_ready", 32'(b.fetch_ready), 1);
    sb.push_back({2'd3, 18'h00ABC});
    tick();
    b.fetch_req = 1'b0;
    chk("b2b_req", 32'(b.mem_req), 1);
    chk("b2b_addr", 32'(b.mem_addr), 32'h13);
    chk("b2b_no_valid", 32'(b.instr_valid), 0);
    b.mem_ack = 1'b1;
    b.mem_rdata = 18'h00ABC;
    tick();
    b.mem_ack = 1'b0;
    chk("b2b_valid", 32'(b.instr_valid), 1);
    tick();
    // ack arrives on the final wait cycle
    start(8'h44, 2'd0);
    repeat (15) tick();
    chk("coll_still_req", 32'(b.mem_req), 1);
    b.mem_ack = 1'b1;
    b.mem_rdata = 18'h2F00F;
    sb.push_back({2'd0, 18'h2F00F});
    tick();
    b.mem_ack = 1'b0;
    chk("coll_valid", 32'(b.instr_valid), 1);
    chk("coll_no_error", 32'(b.fetch_error), 0);
    tick();
    chk("coll_no_error2", 32'(b.fetch_error), 0);
    // flush together with ack in REQ
    start(8'h50, 2'd1);
    b.mem_ack = 1'b1;
    b.flush = 1'b1;
    b.mem_rdata = 18'h11111;
    tick();
    b.mem_ack = 1'b0;
    b.flush = 1'b0;
    chk("flreq_req", 32'(b.mem_req), 0);
    chk("flreq_ready", 32'(b.fetch_ready), 1);
    for (int i = 0; i < 3; i++) begin
      chk("flreq_no_valid", 32'(b.instr_valid), 0);
      tick();
    end
    // flush in VALID also blocks a concurrent fetch_req
    b.instr_ready = 1'b0;
    start(8'h60, 2'd2);
    b.mem_ack = 1'b1;
    b.mem_rdata = 18'h0F0F0;
    tick();
    b.mem_ack = 1'b0;
    chk("flv_valid", 32'(b.instr_valid), 1);
    b.flush = 1'b1;
    b.fetch_req = 1'b1;
    b.pc = 8'h61;
    tick();
    b.flush = 1'b0;
    b.fetch_req = 1'b0;
    chk("flv_drop", 32'(b.instr_valid), 0);
    chk("flv_no_req", 32'(b.mem_req), 0);
    chk("flv_ready", 32'(b.fetch_ready), 1);
    chk("flv_no_error", 32'(b.fetch_error), 0);
    b.instr_ready = 1'b1;
    // timeout and late ack
    run_timeout(2'd3);
    b.mem_ack = 1'b1;
    b.mem_rdata = 18'h3FFFF;
    tick();
    b.mem_ack = 1'b0;
    chk("late_ack_no_valid", 32'(b.instr_valid), 0);
    chk("late_ack_idle", 32'(b.fetch_ready), 1);
    chk("late_ack_sticky", 32'(b.fetch_error), 1);
    // reset in REQ
    start(8'h70, 2'd1);
    chk("rreq_req", 32'(b.mem_req), 1);
    reset = 1'b1;
    tick();
    chk_reset("rreq");
    reset = 1'b0;
    // reset in VALID with fetch_error set
    run_timeout(2'd2);
    b.instr_ready = 1'b0;
    start(8'h71, 2'd3);
    b.mem_ack = 1'b1;
    b.mem_rdata = 18'h22222;
    tick();
    b.mem_ack = 1'b0;
    chk("rval_valid", 32'(b.instr_valid), 1);
    chk("rval_error", 32'(b.fetch_error), 1);
    reset = 1'b1;
    tick();
    chk_reset("rval");
    reset = 1'b0;
    b.instr_ready = 1'b1;
    tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
